// File: rtl/fetch_queue.sv
// Fetch stage plus circular instruction queue between imem and decode.
// Optional perf counters (stall_cnt, flush_cnt) are built when FETCHQ_PERF_EN is defined.
module fetch_queue #(
  parameter int ADDR_LEN    = 32,
  parameter int INSN_LEN    = 32,
  parameter int LINE_WORDS  = 4,
  parameter int FETCH_WIDTH = 2,
  parameter int DEQ_WIDTH   = 2,
  parameter int DEPTH       = 8,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [ADDR_LEN-1:0]            pc,
  input  logic [LINE_WORDS*INSN_LEN-1:0] idata,
  input  logic                           idata_valid,
  input  logic                           redirect,
  input  logic [ADDR_LEN-1:0]            redirect_pc,
  output logic                           fetch_stall,
  input  logic                           deq_ready,
  output logic [DEQ_WIDTH*INSN_LEN-1:0]  out_inst,
  output logic [DEQ_WIDTH*ADDR_LEN-1:0]  out_pc,
  output logic [DEQ_WIDTH-1:0]           out_valid,
  output logic [$clog2(DEPTH):0]         count
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    flush_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSN_LEN-1:0] mem_inst [DEPTH];
  logic [ADDR_LEN-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]    head, tail;

  logic [INSN_LEN-1:0] line_word [LINE_WORDS];
  logic [INSN_LEN-1:0] enq_inst  [FETCH_WIDTH];
  logic [ADDR_LEN-1:0] enq_pc    [FETCH_WIDTH];
  logic [OFF_W-1:0]    off;
  logic [CNT_W-1:0]    n, d, free;
  logic                enq, deq;

  // Fetch never crosses the line end, so n shrinks near the last word.
  always_comb begin
    off  = pc[OFF_W+1:2];
    free = CNT_W'(DEPTH) - count;
    if (FETCH_WIDTH < LINE_WORDS - int'(off)) n = CNT_W'(FETCH_WIDTH);
    else                                      n = CNT_W'(LINE_WORDS - int'(off));
    d = (count > CNT_W'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : count;
    enq         = idata_valid && !redirect && (free >= n);
    fetch_stall = idata_valid && !redirect && (free < n);
    deq         = deq_ready && !redirect;
  end

  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++)
      line_word[k] = idata[k*INSN_LEN +: INSN_LEN];
    // Slots at or beyond n may select past the line end; they are never written.
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      enq_inst[j] = line_word[off + OFF_W'(j)];
      enq_pc[j]   = pc + ADDR_LEN'(4 * j);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count/head/tail alone.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CNT_W'(j) < n) begin
          mem_inst[tail + PTR_W'(j)] <= enq_inst[j];
          mem_pc[tail + PTR_W'(j)]   <= enq_pc[j];
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= {redirect_pc[ADDR_LEN-1:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(n);
        pc   <= pc + (ADDR_LEN'(n) << 2);
      end
      if (deq) head <= head + PTR_W'(d);
      count <= count + (enq ? n : '0) - (deq ? d : '0);
    end
  end

  always_comb begin
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      out_inst[i*INSN_LEN +: INSN_LEN] = mem_inst[head + PTR_W'(i)];
      out_pc[i*ADDR_LEN +: ADDR_LEN]   = mem_pc[head + PTR_W'(i)];
      out_valid[i]                     = count > CNT_W'(i);
    end
  end

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fetch_stall) stall_cnt <= stall_cnt + 32'd1;
      if (redirect)    flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a queue-based reference model
// predicts dequeued instructions; a negedge monitor compares them.
module tb_fetch_queue;
  localparam int ADDR_LEN = 32;
  localparam int INSN_LEN = 32;
  localparam int LW       = 4;
  localparam int FW       = 2;
  localparam int DW       = 2;
  localparam int DEPTH    = 8;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset;
  logic [ADDR_LEN-1:0]       pc;
  logic [LW*INSN_LEN-1:0]    idata;
  logic                      idata_valid;
  logic                      redirect;
  logic [ADDR_LEN-1:0]       redirect_pc;
  logic                      fetch_stall;
  logic                      deq_ready;
  logic [DW*INSN_LEN-1:0]    out_inst;
  logic [DW*ADDR_LEN-1:0]    out_pc;
  logic [DW-1:0]             out_valid;
  logic [CW-1:0]             count;
`ifdef FETCHQ_PERF_EN
  logic [31:0]               stall_cnt, flush_cnt;
  int unsigned               m_stall, m_flush;
`endif

  fetch_queue #(
    .ADDR_LEN(ADDR_LEN), .INSN_LEN(INSN_LEN), .LINE_WORDS(LW),
    .FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .idata(idata), .idata_valid(idata_valid),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_stall(fetch_stall),
    .deq_ready(deq_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_valid(out_valid), .count(count)
`ifdef FETCHQ_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  int          m_count;
  bit          started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory image: every address maps to a distinct word.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [LW*INSN_LEN-1:0] line_for(input logic [31:0] a);
    logic [LW*INSN_LEN-1:0] r;
    logic [31:0] base;
    base = a & ~32'(LW*4 - 1);
    for (int k = 0; k < LW; k++) r[k*INSN_LEN +: INSN_LEN] = inst_at(base + 32'(4*k));
    return r;
  endfunction

  function automatic int fetch_n(input logic [31:0] a);
    int off;
    off = int'((a >> 2) % 32'(LW));
    return (FW < LW - off) ? FW : LW - off;
  endfunction

  // One clock cycle: drive inputs, check pre-edge state, then advance the model.
  task automatic cycle(input bit rst, input bit v, input bit rd, input bit redir,
                       input logic [31:0] rpc);
    int n, d, free;
    bit exp_stall;
    entry_t e;
    reset = rst; idata_valid = v; deq_ready = rd; redirect = redir; redirect_pc = rpc;
    idata = line_for(m_pc);
    #1;
    n = fetch_n(m_pc);
    free = DEPTH - m_count;
    d = (m_count < DW) ? m_count : DW;
    exp_stall = v && !redir && (free < n);
    if (started) begin
      check("pc", pc, m_pc);
      check("count", count, m_count);
      check("fetch_stall", fetch_stall, exp_stall);
      check("count_le_depth", 64'(count <= CW'(DEPTH)), 1);
`ifdef FETCHQ_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_pc = '0; m_count = 0; exp_q.delete(); started = 1'b1;
    end else if (redir) begin
      m_pc = rpc & ~32'h3; m_count = 0; exp_q.delete();
    end else begin
      if (v && free >= n) begin
        for (int j = 0; j < n; j++) begin
          e.pc = m_pc + 32'(4*j);
          e.inst = inst_at(e.pc);
          exp_q.push_back(e);
        end
        m_pc += 32'(4*n);
        m_count += n;
      end
      if (rd) m_count -= d;
    end
`ifdef FETCHQ_PERF_EN
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (exp_stall) m_stall++;
      if (redir) m_flush++;
    end
`endif
    #1;
  endtask

  // Monitor: checks slot validity and pops the scoreboard on every consumed slot.
  int          mon_k;
  logic [DW-1:0] mon_mask;
  entry_t      mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (started && reset !== 1'b1) begin
        mon_k = (exp_q.size() < DW) ? exp_q.size() : DW;
        mon_mask = DW'((1 << mon_k) - 1);
        check("out_valid", out_valid, mon_mask);
        if (deq_ready && !redirect) begin
          for (int i = 0; i < DW; i++) begin
            if (out_valid[i]) begin
              if (exp_q.size() == 0) begin
                check("spurious_slot", out_valid[i], 0);
              end else begin
                mon_e = exp_q.pop_front();
                check("deq_pc", out_pc[i*ADDR_LEN +: ADDR_LEN], mon_e.pc);
                check("deq_inst", out_inst[i*INSN_LEN +: INSN_LEN], mon_e.inst);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    m_pc = '0; m_count = 0;
`ifdef FETCHQ_PERF_EN
    m_stall = 0; m_flush = 0;
`endif
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // First line at pc 0: two words A, B enqueued.
    cycle(0, 1, 0, 0, 0);
    check("t1_pc", pc, 32'h8);
    check("t1_count", count, 2);
    check("t1_slot0_pc", out_pc[0 +: ADDR_LEN], 32'h0);
    check("t1_slot1_pc", out_pc[ADDR_LEN +: ADDR_LEN], 32'h4);
    check("t1_slot0_inst", out_inst[0 +: INSN_LEN], inst_at(32'h0));

    // Last word of a line: only one entry, no wrap to word 0.
    cycle(0, 0, 0, 1, 32'hC);
    cycle(0, 1, 0, 0, 0);
    check("t2_pc", pc, 32'h10);
    check("t2_count", count, 1);
    check("t2_valid", out_valid, 2'b01);
    check("t2_slot0_pc", out_pc[0 +: ADDR_LEN], 32'hC);

    // Fill to DEPTH, stall, drain without enqueue, then resume.
    cycle(0, 0, 0, 1, 32'h0);
    repeat (4) cycle(0, 1, 0, 0, 0);
    check("t3_full", count, 8);
    cycle(0, 1, 0, 0, 0);
    check("t3_hold_pc", pc, 32'h20);
    cycle(0, 1, 1, 0, 0);
    check("t3_drain_count", count, 6);
    check("t3_drain_pc", pc, 32'h20);
    cycle(0, 1, 0, 0, 0);
    check("t3_resume_count", count, 8);
    check("t3_resume_pc", pc, 32'h28);

    // Count 7 with a two-word fetch pending: stall with one slot free.
    cycle(0, 0, 0, 1, 32'h4);
    repeat (4) cycle(0, 1, 0, 0, 0);
    check("t3b_count", count, 7);
    cycle(0, 1, 0, 0, 0);
    check("t3b_hold_pc", pc, 32'h20);
    check("t3b_hold_count", count, 7);

    // Steady-state streaming wraps the pointers.
    repeat (20) cycle(0, 1, 1, 0, 0);

    // Redirect with misaligned target while holding 5 entries.
    cycle(0, 0, 0, 1, 32'h4);
    repeat (3) cycle(0, 1, 0, 0, 0);
    check("t5_pre_count", count, 5);
    cycle(0, 1, 0, 1, 32'h1007);
    check("t5_count", count, 0);
    check("t5_valid", out_valid, 2'b00);
    check("t5_pc", pc, 32'h1004);
    cycle(0, 1, 0, 0, 0);
    check("t5_slot0_pc", out_pc[0 +: ADDR_LEN], 32'h1004);
    check("t5_slot1_pc", out_pc[ADDR_LEN +: ADDR_LEN], 32'h1008);
    repeat (3) cycle(0, 0, 1, 0, 0);

`ifdef FETCHQ_PERF_EN
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 32'h40);
    check("perf_stall3", stall_cnt, 3);
    check("perf_flush1", flush_cnt, 1);
    cycle(1, 0, 0, 0, 0);
    check("perf_rst_stall", stall_cnt, 0);
    check("perf_rst_flush", flush_cnt, 0);
`endif

    // Randomized traffic, including occasional redirect and mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 31) == 0,
            $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
